// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default frame parameters
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// rtl/rx_synchronizer.sv - two-flop synchronizer for the asynchronous rx line
module rx_synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, LSB first, one stop bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    rx_synchronizer #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                // Start edge is taken immediately so a frame can follow a stop sample directly.
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rxs ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rxs) begin
                                data_out <= shift_reg;
                                rx_done  <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_error;

    int compared   = 0;
    int mismatched = 0;
    int both_cnt   = 0;
    bit tick_en    = 1'b1;
    int div        = 0;

    bit         got_err[$];
    logic [7:0] got_data[$];
    bit         exp_err[$];
    logic [7:0] exp_data[$];
    logic [7:0] last_data = 8'h00;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .rx          (rx),
        .data_out    (data_out),
        .rx_done     (rx_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk wide, every 4 clks, gated by tick_en.
    initial begin
        forever begin
            @(negedge clk);
            div  = (div + 1) % 4;
            tick = tick_en && (div == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rx_done) begin
                got_err.push_back(1'b0);
                got_data.push_back(data_out);
            end
            if (frame_error) begin
                got_err.push_back(1'b1);
                got_data.push_back(data_out);
            end
            if (rx_done && frame_error) both_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c++;
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    // A bad stop bit is held low only past its centre, then the line idles.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (stop_ok) begin
            send_bit(1'b1);
            exp_err.push_back(1'b0);
            exp_data.push_back(d);
            last_data = d;
        end else begin
            rx = 1'b0;
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(OS);
            exp_err.push_back(1'b1);
            exp_data.push_back(last_data);
        end
    endtask

    task automatic check_events(input string name);
        repeat (4) @(negedge clk);
        compared++;
        if (got_err.size() != exp_err.size()) begin
            mismatched++;
            $display("FAIL %s event count: got %0d expected %0d", name, got_err.size(), exp_err.size());
        end
        for (int i = 0; i < got_err.size() && i < exp_err.size(); i++) begin
            compared++;
            if (got_err[i] !== exp_err[i] || got_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL %s event %0d: got err=%0b data=%02h expected err=%0b data=%02h",
                         name, i, got_err[i], got_data[i], exp_err[i], exp_data[i]);
            end
        end
        compared++;
        if (data_out !== last_data) begin
            mismatched++;
            $display("FAIL %s data_out: got %02h expected %02h", name, data_out, last_data);
        end
        got_err.delete();
        got_data.delete();
        exp_err.delete();
        exp_data.delete();
    endtask

    task automatic check_idle(input string name);
        compared++;
        if (dut.state !== IDLE) begin
            mismatched++;
            $display("FAIL %s state: got %0d expected %0d", name, dut.state, IDLE);
        end
    endtask

    task automatic check_quiet_outputs(input string name);
        compared++;
        if (data_out !== 8'h00 || rx_done !== 1'b0 || frame_error !== 1'b0) begin
            mismatched++;
            $display("FAIL %s outputs: got data=%02h done=%0b ferr=%0b expected 00/0/0",
                     name, data_out, rx_done, frame_error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        check_idle("reset");
        rst = 1'b1;
        wait_ticks(4);
        check_events("reset_quiet");
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1);
        check_events("basic_55");
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        check_events("glitch");
        check_idle("glitch");
        send_frame(8'h81, 1'b1);
        check_events("after_glitch_81");
    endtask

    task automatic test_frame_error();
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b0);
        wait_ticks(10);
        check_events("frame_error");
        check_idle("frame_error");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check_events("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        wait_ticks(8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet_outputs("reset_mid");
        rx = 1'b1;
        wait_ticks(4);
        check_quiet_outputs("reset_mid_hold");
        rst = 1'b1;
        last_data = 8'h00;
        wait_ticks(20);
        check_events("reset_abort");
        check_idle("reset_abort");
        send_frame(8'h3C, 1'b1);
        check_events("after_reset_3C");
    endtask

    task automatic test_tick_pause();
        logic [7:0] d = 8'hC5;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                rx = d[i];
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                compared++;
                if (dut.state !== DATA || got_err.size() != 0) begin
                    mismatched++;
                    $display("FAIL tick_pause frozen: got state=%0d events=%0d expected state=%0d events=0",
                             dut.state, got_err.size(), DATA);
                end
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
        exp_err.push_back(1'b0);
        exp_data.push_back(d);
        last_data = d;
        check_events("tick_pause");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] d;
            bit ok;
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            if ($urandom_range(0, 1) == 1) begin
                rx = 1'b1;
                wait_ticks($urandom_range(1, 20));
            end
        end
        check_events("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_pause();
        test_random();
        compared++;
        if (both_cnt != 0) begin
            mismatched++;
            $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of tick pulses per bit period (even, >= 8).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tick, input, 1, one-clk-wide enable pulse at OVERSAMPLE x baud rate, from the baud tick generator.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port data_out, output, DATA_BITS, last correctly framed byte.
REQ-008 SHALL have port rx_done, output, 1, one-clk pulse when data_out is updated.
REQ-009 SHALL have port frame_error, output, 1, one-clk pulse when the stop bit is sampled low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-011 SHALL implement the FSM states IDLE, START, DATA and STOP, with a tick counter of width clog2(OVERSAMPLE) and a bit counter of width clog2(DATA_BITS).
REQ-012 IDLE: on rxs==0, SHALL go to START and clear the tick counter; this transition does not require tick.
REQ-013 START: the tick counter SHALL advance only on tick; at count OVERSAMPLE/2-1, if rxs==0 then go to DATA and clear both counters, else return to IDLE (glitch reject, no output).
REQ-014 DATA: on the tick where the count reaches OVERSAMPLE-1, SHALL shift rxs into the shift register MSB with right shift (LSB first on the line), clear the tick counter and increment the bit counter; after bit DATA_BITS-1 it SHALL go to STOP.
REQ-015 STOP: at tick count OVERSAMPLE-1 (mid stop bit), if rxs==1 SHALL load data_out from the shift register and pulse rx_done; else SHALL pulse frame_error and leave data_out unchanged; in both cases it SHALL return to IDLE.
REQ-016 rx_done and frame_error SHALL be registered, asserted exactly in the clk cycle after the stop-sample tick, and never asserted together.
REQ-017 Without tick pulses, START, DATA and STOP SHALL hold state and counters.
REQ-018 A start edge arriving immediately after the stop sample SHALL be accepted, so back-to-back frames need no idle gap.
REQ-019 Sampling SHALL occur at the bit centre +/- 1 tick; the latency from the stop-bit centre to rx_done SHALL be 1 clk plus 2 synchronizer clks.

Reset
REQ-020 While rst==0, the state SHALL be IDLE, the counters and shift register 0, data_out 0, rx_done 0, frame_error 0 and the synchronizer flops 1.
REQ-021 A reset asserted mid-frame SHALL abort the frame with no output pulse; after rst is released the block SHALL wait for the next falling edge.

Structure
REQ-022 Package uart_pkg SHALL hold the FSM state enum (2-bit) and the default DATA_BITS/OVERSAMPLE constants shared with the future uart_tx.
REQ-023 The synchronizer SHALL be the single sub-module rx_synchronizer (2-flop, reset value parameter = 1).
REQ-024 uart_rx SHALL contain no baud divider; tick is external.

Verification
REQ-025 Frame 0x55 with a valid stop, tick every 4 clks, OVERSAMPLE=16 -> exactly one rx_done, data_out=0x55, frame_error never high.
REQ-026 rx low for 4 ticks then high -> no rx_done and no frame_error, FSM back in IDLE; a following frame 0x81 is received correctly.
REQ-027 Frame 0xA3 with the stop bit low after a valid 0x55 -> one frame_error pulse, no rx_done, data_out stays 0x55.
REQ-028 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, data_out 0x00 then 0xFF.
REQ-029 rst pulsed low during data bit 3 of frame 0x96 -> all outputs 0 during reset, no pulse for 0x96; the next frame 0x3C gives rx_done with data_out=0x3C.
REQ-030 tick held low for 100 clks in the middle of DATA -> state and counters frozen; the frame completes correctly once ticks resume.
